// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: walks a one-bit ALU slice across WIDTH bit positions, LSB first,
// keeping the ripple carry in a flop and resolving SLT/overflow at the MSB step.
module serial_alu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_ctl,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, acc, assembled, res_final;
    logic [3:0]       ctl_q;
    logic [CW-1:0]    count;
    logic             carry, carry_out, ai, bi, sum, bit_val;

    function automatic logic majority(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (count == LAST) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = (state == IDLE);
        done  = (state == DONE);
    end

    // One-bit slice at position count; ctl_q = {Ainvert, Binvert, Operation}
    always_comb begin
        ai        = a_q[count] ^ ctl_q[3];
        bi        = b_q[count] ^ ctl_q[2];
        sum       = ai ^ bi ^ carry;
        carry_out = majority(ai, bi, carry);
        case (ctl_q[1:0])
            2'b00:   bit_val = ai & bi;
            2'b01:   bit_val = ai | bi;
            2'b10:   bit_val = sum;
            default: bit_val = 1'b0;
        endcase
        assembled        = acc;
        assembled[count] = bit_val;
        res_final        = assembled;
        // At the MSB, sum is the sign of a-b: this is the Less feedback into bit 0.
        if (ctl_q[1:0] == 2'b11) res_final[0] = sum;
    end

    // Operand capture and partial-result accumulation need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q   <= a;
            b_q   <= b;
            ctl_q <= alu_ctl;
            acc   <= '0;
        end else if (state == RUN) begin
            acc <= assembled;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count    <= '0;
            carry    <= 1'b0;
            result   <= '0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (state == IDLE && start) begin
            carry <= alu_ctl[2];
            count <= '0;
        end else if (state == RUN) begin
            carry <= carry_out;
            if (count == LAST) begin
                count    <= '0;
                result   <= res_final;
                zero     <= (res_final == '0);
                overflow <= (ctl_q[1:0] == 2'b10) & (carry ^ carry_out);
            end else begin
                count <= count + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: word-level reference model with a per-cycle
// compare process, plus directed vectors with hand-computed results.
module tb_serial_alu_seq;
    localparam int WIDTH = 32;

    logic             clk, rst_n, start;
    logic [WIDTH-1:0] a, b;
    logic [3:0]       alu_ctl;
    logic             ready, done, zero, overflow;
    logic [WIDTH-1:0] result;

    int n_checks = 0;
    int n_fail   = 0;

    serial_alu_seq #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .alu_ctl(alu_ctl),
        .ready(ready), .done(done), .result(result), .zero(zero), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level reference: whole-operand arithmetic, no bit stepping.
    function automatic void compute(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic [3:0] c, output logic [WIDTH-1:0] r,
                                    output logic z, output logic o);
        logic [WIDTH-1:0] ai, bi;
        logic [WIDTH:0]   s;
        ai = c[3] ? ~x : x;
        bi = c[2] ? ~y : y;
        s  = {1'b0, ai} + {1'b0, bi} + {{WIDTH{1'b0}}, c[2]};
        case (c[1:0])
            2'b00:   r = ai & bi;
            2'b01:   r = ai | bi;
            2'b10:   r = s[WIDTH-1:0];
            default: r = {{(WIDTH-1){1'b0}}, s[WIDTH-1]};
        endcase
        o = (c[1:0] == 2'b10) && (ai[WIDTH-1] == bi[WIDTH-1]) && (s[WIDTH-1] != ai[WIDTH-1]);
        z = (r == '0);
    endfunction

    // Model state: cycles remaining until idle, plus expected held outputs.
    logic             armed = 1'b0;
    int               remaining = 0;
    logic [WIDTH-1:0] exp_r, pend_r;
    logic             exp_z, exp_o, pend_z, pend_o;

    always @(posedge clk) begin
        if (!rst_n) begin
            armed = 1'b1;
            remaining = 0;
            exp_r = '0; exp_z = 1'b0; exp_o = 1'b0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 1) begin
                exp_r = pend_r; exp_z = pend_z; exp_o = pend_o;
            end
        end else if (start) begin
            compute(a, b, alu_ctl, pend_r, pend_z, pend_o);
            remaining = WIDTH + 1;
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("ready", {31'b0, ready}, {31'b0, remaining == 0});
            check("done", {31'b0, done}, {31'b0, remaining == 1});
            check("result", result, exp_r);
            check("zero", {31'b0, zero}, {31'b0, exp_z});
            check("overflow", {31'b0, overflow}, {31'b0, exp_o});
        end
    end

    task automatic run_op(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          input logic [3:0] c, input logic [WIDTH-1:0] er,
                          input logic ez, input logic eo);
        int guard, n;
        guard = 0;
        while (!ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) check({name, "_ready_timeout"}, 32'd0, 32'd1);
        a = x; b = y; alu_ctl = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        // Scramble inputs while the operation runs; they must not leak in.
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (!done) begin
                a = $urandom; b = $urandom; alu_ctl = 4'($urandom);
            end
        end
        check({name, "_latency"}, n, 32'd32);
        check({name, "_res"}, result, er);
        check({name, "_zero"}, {31'b0, zero}, {31'b0, ez});
        check({name, "_ovf"}, {31'b0, overflow}, {31'b0, eo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones, last_t, n;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; alu_ctl = 4'b0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("rst_ready", {31'b0, ready}, 32'd1);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", {31'b0, zero}, 32'd0);
        check("rst_ovf", {31'b0, overflow}, 32'd0);

        run_op("add_ovf",  32'h7FFFFFFF, 32'h00000001, 4'b0010, 32'h80000000, 1'b0, 1'b1);
        run_op("sub_zero", 32'd5,        32'd5,        4'b0110, 32'h00000000, 1'b1, 1'b0);
        run_op("sub_ovf",  32'h80000000, 32'h00000001, 4'b0110, 32'h7FFFFFFF, 1'b0, 1'b1);
        run_op("slt_lt",   32'd3,        32'd7,        4'b0111, 32'h00000001, 1'b0, 1'b0);
        run_op("slt_ge",   32'd7,        32'd3,        4'b0111, 32'h00000000, 1'b1, 1'b0);
        run_op("and",      32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 32'hF000F000, 1'b0, 1'b0);
        run_op("or",       32'hF0F0F0F0, 32'hFF00FF00, 4'b0001, 32'hFFF0FFF0, 1'b0, 1'b0);
        run_op("nor",      32'hF0F0F0F0, 32'hFF00FF00, 4'b1100, 32'h000F000F, 1'b0, 1'b0);

        // start held high: back-to-back accepts every WIDTH+2 cycles
        @(negedge clk);
        a = 32'd10; b = 32'd20; alu_ctl = 4'b0010; start = 1'b1;
        dones = 0; last_t = -1;
        for (int i = 0; i < 3 * (WIDTH + 2); i++) begin
            @(negedge clk);
            if (done) begin
                if (last_t >= 0) check("held_period", i - last_t, WIDTH + 2);
                last_t = i;
                dones++;
                check("held_res", result, 32'd30);
            end
        end
        start = 1'b0;
        check("held_dones", dones, 32'd3);

        // reset while count == 10 aborts the operation
        while (!ready) @(negedge clk);
        a = 32'd100; b = 32'd200; alu_ctl = 4'b0010; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_result", result, 32'd0);
        check("abort_zero", {31'b0, zero}, 32'd0);
        check("abort_ovf", {31'b0, overflow}, 32'd0);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n, 32'd0);
        run_op("add_after_rst", 32'd2, 32'd3, 4'b0010, 32'd5, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial 32-bit ALU sequencer that drives the single-bit ALU slice datapath one bit position per clock, LSB first, with the MSB position last.
- Keeps the ripple carry in a flip-flop and captures Set/Overflow at the MSB step.
- Feeds Set back as the Less input of bit 0 for SLT.
- Sits between the ALU control decode and the register-file write-back. It gives a compact multi-cycle ALU with a start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits; minimum 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; accepted on a rising edge when ready=1
- a  input  WIDTH  operand A, sampled only at accept
- b  input  WIDTH  operand B, sampled only at accept
- alu_ctl  input  4  {Ainvert, Binvert, Operation[1:0]}, sampled only at accept
- ready  output  1  high when idle and able to accept
- done  output  1  one-cycle pulse; result/zero/overflow valid
- result  output  WIDTH  operation result, held until next accept
- zero  output  1  result == 0
- overflow  output  1  signed overflow of add/sub

Behaviour:
- Reset: rst_n sampled low at a rising edge gives state=IDLE, ready=1, done=0, result=0, zero=0, overflow=0, bit counter=0, carry=0.
- Reset mid-operation aborts the operation. No done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - ready=1.
  - start=1 at an edge latches a, b, alu_ctl into internal registers, sets carry<=Binvert, sets count<=0, and moves to RUN with ready<=0.
- RUN: one bit per cycle, at index count.
  - ai = a_q[count] ^ Ainvert; bi = b_q[count] ^ Binvert.
  - sum = ai ^ bi ^ carry; carry <= majority(ai, bi, carry).
  - Operation 00 (AND): bit = ai & bi.
  - Operation 01 (OR): bit = ai | bi.
  - Operation 10 (ADD): bit = sum.
  - Operation 11 (SLT): bit = 0 at every index during RUN. Bit 0 is overwritten at the end.
  - The computed bit is written into result_next[count]. The result output itself does not change during RUN.
- MSB step (count==WIDTH-1):
  - set = sum at the MSB; ovf = carry_in_msb ^ carry_out_msb.
  - result <= result_next with the MSB bit included.
  - If Operation==11, result[0] <= set. This is raw MSB of a-b with no overflow correction.
  - overflow <= ovf only when Operation==10, else 0.
  - zero <= (final result == 0).
  - State moves to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge: move to IDLE, done<=0, ready<=1.
- Latency:
  - Accept at edge 0. Bits processed at edges 1..WIDTH.
  - done is high in the cycle following edge WIDTH.
  - ready returns after edge WIDTH+1.
  - Minimum start-to-start period is WIDTH+2 cycles.
- start while ready=0 (RUN/DONE) is ignored. No queuing.
- Changes on a, b or alu_ctl after accept have no effect.
- Decode is by bit field, so every alu_ctl code is legal. Canonical codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
- A carry out of the MSB is discarded and not exposed.

Test Plan (WIDTH=32):
- ADD overflow: ADD a=0x7FFFFFFF b=0x00000001 -> result=0x80000000, overflow=1, zero=0, done exactly 32 cycles after the accept edge, ready=0 throughout.
- SUB to zero: SUB a=5 b=5 -> result=0, zero=1, overflow=0. Also SUB a=0x80000000 b=1 -> result=0x7FFFFFFF, overflow=1.
- SLT: SLT a=3 b=7 -> result=0x00000001. Then SLT a=7 b=3 -> result=0x00000000, zero=1, overflow=0 in both.
- Logic ops, a=0xF0F0F0F0 b=0xFF00FF00:
  - AND -> 0xF000F000.
  - OR -> 0xFFF0FFF0.
  - NOR -> 0x000F000F.
  - overflow=0 for all three.
- Handshake:
  - start held high continuously: operations are accepted only when ready=1, period is 34 cycles.
  - Operands and alu_ctl are toggled during RUN: result is unaffected.
  - Only one done pulse per accepted operation.
- Reset mid-run: rst_n=0 for one edge while count=10 -> next cycle ready=1, result=0, zero=0, overflow=0, no done pulse. A following ADD 2+3 returns 5.
